// File: rtl/building_stripe_edge_scan_if.sv
// Pixel beat inputs and per-frame latched stripe-edge results for building_stripe_edge_scan.
// The pixel source drives through master; the scanner uses slave.
interface building_stripe_edge_scan_if;
    logic        in_valid;
    logic        sop;
    logic        eop;
    logic        is_white;
    logic [10:0] f_slot_7_blackToWhite;
    logic [10:0] f_slot_7_whiteToBlack;
    logic [10:0] f_slot_8_blackToWhite;
    logic [10:0] f_slot_8_whiteToBlack;
    logic [10:0] f_slot_9_blackToWhite;
    logic [10:0] f_slot_9_whiteToBlack;
    logic [10:0] f_slot_10_blackToWhite;
    logic [10:0] f_slot_10_whiteToBlack;
    logic [10:0] left_most_bound;
    logic [10:0] right_most_bound;
    logic [4:0]  left_slot;
    logic [4:0]  right_slot;
    logic [4:0]  center_slot;
    logic [5:0]  edge_count;
    logic        frame_done;

    modport master (
        output in_valid, sop, eop, is_white,
        input  f_slot_7_blackToWhite, f_slot_7_whiteToBlack,
               f_slot_8_blackToWhite, f_slot_8_whiteToBlack,
               f_slot_9_blackToWhite, f_slot_9_whiteToBlack,
               f_slot_10_blackToWhite, f_slot_10_whiteToBlack,
               left_most_bound, right_most_bound,
               left_slot, right_slot, center_slot, edge_count, frame_done
    );

    modport slave (
        input  in_valid, sop, eop, is_white,
        output f_slot_7_blackToWhite, f_slot_7_whiteToBlack,
               f_slot_8_blackToWhite, f_slot_8_whiteToBlack,
               f_slot_9_blackToWhite, f_slot_9_whiteToBlack,
               f_slot_10_blackToWhite, f_slot_10_whiteToBlack,
               left_most_bound, right_most_bound,
               left_slot, right_slot, center_slot, edge_count, frame_done
    );
endinterface

// File: rtl/building_stripe_edge_scan.sv
// Scans one binarised row per frame for debounced black/white stripe edges and latches
// slot 7..10 edge positions, outer bounds and slot indices on every eop beat.
module building_stripe_edge_scan #(
    parameter int IMAGE_W  = 640,
    parameter int SLOT_W   = 40,
    parameter int SCAN_ROW = 240,
    parameter int MIN_RUN  = 3
) (
    input  logic clk,
    input  logic reset_n,
    building_stripe_edge_scan_if.slave bus
);
    localparam int NSLOTS = IMAGE_W / SLOT_W;

    logic       r_armed, r_cur, r_rowDone;
    logic [9:0] r_x, r_y, r_candX, r_left, r_right;
    logic [3:0] r_runCnt;
    logic [9:0] r_b2w [4];
    logic [9:0] r_w2b [4];
    logic [4:0] r_lslot, r_rslot;
    logic [5:0] r_edgeCnt;

    logic [9:0] r_oB2w [4];
    logic [9:0] r_oW2b [4];
    logic [9:0] r_oLeft, r_oRight;
    logic [4:0] r_oLslot, r_oRslot, r_oCslot;
    logic [5:0] r_oEdgeCnt;
    logic       r_frameDone;

    logic       w_armed, w_cur, w_rowDone, w_take, w_latch;
    logic [9:0] w_x, w_y, w_px, w_py, w_candX, w_left, w_right;
    logic [3:0] w_runCnt, w_newCnt;
    logic [9:0] w_b2w [4];
    logic [9:0] w_w2b [4];
    logic [4:0] w_lslot, w_rslot, w_slot;
    logic [1:0] w_idx;
    logic [5:0] w_edgeCnt;

    // Constant compare chain instead of a divider: slot = x/SLOT_W + 1.
    function automatic logic [4:0] slotOf(input logic [9:0] x);
        logic [4:0] s;
        s = 5'd1;
        for (int k = 1; k < NSLOTS; k++)
            if (x >= 10'(k * SLOT_W)) s = 5'(k + 1);
        return s;
    endfunction

    always_comb begin
        w_armed = r_armed;     w_cur = r_cur;         w_rowDone = r_rowDone;
        w_x = r_x;             w_y = r_y;             w_candX = r_candX;
        w_left = r_left;       w_right = r_right;     w_runCnt = r_runCnt;
        w_b2w = r_b2w;         w_w2b = r_w2b;         w_lslot = r_lslot;
        w_rslot = r_rslot;     w_edgeCnt = r_edgeCnt; w_px = r_x;
        w_py = r_y;            w_newCnt = 4'd0;       w_slot = 5'd0;
        w_idx = 2'd0;          w_latch = 1'b0;
        w_take = bus.in_valid && (r_armed || bus.sop);
        if (w_take) begin
            if (bus.sop) begin
                w_cur = 1'b0;  w_rowDone = 1'b0; w_candX = '0; w_left = '0; w_right = '0;
                w_runCnt = '0; w_lslot = '0; w_rslot = '0; w_edgeCnt = '0;
                w_b2w = '{default: '0};
                w_w2b = '{default: '0};
                w_px = '0;
                w_py = '0;
            end
            w_armed = 1'b1;
            w_latch = bus.eop;
            if (w_py == 10'(SCAN_ROW)) begin
                if (w_px == 10'd0) begin
                    w_cur    = bus.is_white;
                    w_runCnt = 4'd0;
                end else if (bus.is_white != w_cur) begin
                    w_newCnt = (w_runCnt == 4'd15) ? 4'd15 : w_runCnt + 4'd1;
                    if (w_runCnt == 4'd0) w_candX = w_px;
                    w_runCnt = w_newCnt;
                    if (w_newCnt == 4'(MIN_RUN)) begin
                        w_slot = slotOf(w_candX);
                        w_idx  = 2'(w_slot - 5'd7);
                        if (w_slot >= 5'd7 && w_slot <= 5'd10) begin
                            if (!w_cur && w_b2w[w_idx] == 10'd0) w_b2w[w_idx] = w_candX;
                            if (w_cur && w_w2b[w_idx] == 10'd0)  w_w2b[w_idx] = w_candX;
                        end
                        if (w_edgeCnt == 6'd0) begin
                            w_left  = w_candX;
                            w_lslot = w_slot;
                        end
                        w_right  = w_candX;
                        w_rslot  = w_slot;
                        w_edgeCnt = (w_edgeCnt == 6'd63) ? 6'd63 : w_edgeCnt + 6'd1;
                        w_cur    = !w_cur;
                        w_runCnt = 4'd0;
                    end
                end else begin
                    w_runCnt = 4'd0;
                end
                // A run still unconfirmed at the row end never becomes an edge.
                if (w_px == 10'(IMAGE_W - 1)) begin
                    w_rowDone = 1'b1;
                    w_runCnt  = 4'd0;
                end
            end
            if (w_px == 10'(IMAGE_W - 1)) begin
                w_x = 10'd0;
                w_y = (w_py == 10'd1023) ? w_py : w_py + 10'd1;
            end else begin
                w_x = w_px + 10'd1;
                w_y = w_py;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed <= 1'b0;  r_cur <= 1'b0;   r_rowDone <= 1'b0; r_x <= '0;   r_y <= '0;
            r_candX <= '0;    r_left <= '0;    r_right <= '0;     r_runCnt <= '0;
            r_b2w <= '{default: '0};
            r_w2b <= '{default: '0};
            r_lslot <= '0;    r_rslot <= '0;   r_edgeCnt <= '0;
            r_oB2w <= '{default: '0};
            r_oW2b <= '{default: '0};
            r_oLeft <= '0;    r_oRight <= '0;  r_oLslot <= '0;    r_oRslot <= '0;
            r_oCslot <= '0;   r_oEdgeCnt <= '0; r_frameDone <= 1'b0;
        end else begin
            r_armed <= w_armed; r_cur <= w_cur;     r_rowDone <= w_rowDone; r_x <= w_x; r_y <= w_y;
            r_candX <= w_candX; r_left <= w_left;   r_right <= w_right;     r_runCnt <= w_runCnt;
            r_b2w <= w_b2w;     r_w2b <= w_w2b;     r_lslot <= w_lslot;     r_rslot <= w_rslot;
            r_edgeCnt <= w_edgeCnt;
            r_frameDone <= w_latch;
            // Latch from the post-beat working state so the eop pixel itself counts.
            if (w_latch) begin
                for (int i = 0; i < 4; i++) begin
                    r_oB2w[i] <= w_rowDone ? w_b2w[i] : 10'd0;
                    r_oW2b[i] <= w_rowDone ? w_w2b[i] : 10'd0;
                end
                r_oLeft    <= w_rowDone ? w_left    : 10'd0;
                r_oRight   <= w_rowDone ? w_right   : 10'd0;
                r_oLslot   <= w_rowDone ? w_lslot   : 5'd0;
                r_oRslot   <= w_rowDone ? w_rslot   : 5'd0;
                r_oCslot   <= w_rowDone ? 5'((6'(w_lslot) + 6'(w_rslot)) >> 1) : 5'd0;
                r_oEdgeCnt <= w_rowDone ? w_edgeCnt : 6'd0;
            end
        end
    end

    assign bus.f_slot_7_blackToWhite  = {1'b0, r_oB2w[0]};
    assign bus.f_slot_7_whiteToBlack  = {1'b0, r_oW2b[0]};
    assign bus.f_slot_8_blackToWhite  = {1'b0, r_oB2w[1]};
    assign bus.f_slot_8_whiteToBlack  = {1'b0, r_oW2b[1]};
    assign bus.f_slot_9_blackToWhite  = {1'b0, r_oB2w[2]};
    assign bus.f_slot_9_whiteToBlack  = {1'b0, r_oW2b[2]};
    assign bus.f_slot_10_blackToWhite = {1'b0, r_oB2w[3]};
    assign bus.f_slot_10_whiteToBlack = {1'b0, r_oW2b[3]};
    assign bus.left_most_bound        = {1'b0, r_oLeft};
    assign bus.right_most_bound       = {1'b0, r_oRight};
    assign bus.left_slot              = r_oLslot;
    assign bus.right_slot             = r_oRslot;
    assign bus.center_slot            = r_oCslot;
    assign bus.edge_count             = r_oEdgeCnt;
    assign bus.frame_done             = r_frameDone;
endmodule

// File: tb/tb_building_stripe_edge_scan.sv
// Directed bench: two scanners (MIN_RUN 1 and 3, scan row 2 to keep frames short)
// fed the same pixel stream, results compared against hand-computed values.
module tb_building_stripe_edge_scan;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectorCount = 0;
    int   missCount = 0;
    logic [639:0] pat;

    building_stripe_edge_scan_if bus1 ();
    building_stripe_edge_scan_if bus3 ();

    building_stripe_edge_scan #(.IMAGE_W(640), .SLOT_W(40), .SCAN_ROW(2), .MIN_RUN(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave));
    building_stripe_edge_scan #(.IMAGE_W(640), .SLOT_W(40), .SCAN_ROW(2), .MIN_RUN(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .bus(bus3.slave));

    always #5 clk = ~clk;

    // Order: s7 b2w, s7 w2b, s8 b2w, s8 w2b, s9 b2w, s9 w2b, s10 b2w, s10 w2b,
    // left, right, lslot, rslot, cslot, edge_count.
    int expZero[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int expT1[14]   = '{260, 0, 0, 300, 0, 0, 0, 0, 260, 300, 7, 8, 7, 2};
    int expT2r3[14] = '{270, 0, 0, 0, 0, 340, 0, 0, 270, 340, 7, 9, 8, 2};
    int expT2r1[14] = '{250, 252, 0, 0, 0, 340, 0, 0, 250, 340, 7, 9, 8, 4};
    int expT3[14]   = '{240, 260, 280, 300, 320, 340, 360, 380, 240, 380, 7, 10, 8, 8};
    string names[14] = '{"s7b2w", "s7w2b", "s8b2w", "s8w2b", "s9b2w", "s9w2b", "s10b2w",
                         "s10w2b", "left", "right", "lslot", "rslot", "cslot", "count"};

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkSet(input string tag, input int sel, input int e[14]);
        int obs[14];
        if (sel == 1)
            obs = '{int'(bus1.f_slot_7_blackToWhite), int'(bus1.f_slot_7_whiteToBlack),
                    int'(bus1.f_slot_8_blackToWhite), int'(bus1.f_slot_8_whiteToBlack),
                    int'(bus1.f_slot_9_blackToWhite), int'(bus1.f_slot_9_whiteToBlack),
                    int'(bus1.f_slot_10_blackToWhite), int'(bus1.f_slot_10_whiteToBlack),
                    int'(bus1.left_most_bound), int'(bus1.right_most_bound),
                    int'(bus1.left_slot), int'(bus1.right_slot), int'(bus1.center_slot),
                    int'(bus1.edge_count)};
        else
            obs = '{int'(bus3.f_slot_7_blackToWhite), int'(bus3.f_slot_7_whiteToBlack),
                    int'(bus3.f_slot_8_blackToWhite), int'(bus3.f_slot_8_whiteToBlack),
                    int'(bus3.f_slot_9_blackToWhite), int'(bus3.f_slot_9_whiteToBlack),
                    int'(bus3.f_slot_10_blackToWhite), int'(bus3.f_slot_10_whiteToBlack),
                    int'(bus3.left_most_bound), int'(bus3.right_most_bound),
                    int'(bus3.left_slot), int'(bus3.right_slot), int'(bus3.center_slot),
                    int'(bus3.edge_count)};
        for (int i = 0; i < 14; i++)
            checkOutput($sformatf("%s.r%0d.%s", tag, sel, names[i]), obs[i], e[i]);
    endtask

    task automatic driveBeat(input logic v, input logic s, input logic e, input logic w);
        bus1.in_valid = v; bus1.sop = s; bus1.eop = e; bus1.is_white = w;
        bus3.in_valid = v; bus3.sop = s; bus3.eop = e; bus3.is_white = w;
    endtask

    // Sends a frame from sop up to an eop at (eopY, eopX); row 2 carries pat, other rows noise.
    // With doReset, reset_n drops for the beat at x=265 of the scan row.
    task automatic applyStimulus(input string tag, input int eopY, input int eopX,
                                 input bit doReset, input bit expectDone);
        bit last;
        for (int y = 0; y <= eopY; y++) begin
            for (int x = 0; x < 640; x++) begin
                last = (y == eopY) && (x == eopX);
                @(negedge clk);
                if (doReset && y == 2 && x == 265) begin
                    reset_n = 1'b0;
                    #1;
                    checkSet({tag, ".inReset"}, 1, expZero);
                    checkSet({tag, ".inReset"}, 3, expZero);
                end else begin
                    reset_n = 1'b1;
                end
                driveBeat(1'b1, (x == 0 && y == 0), last,
                          (y == 2) ? pat[x] : logic'(((x >> 3) ^ y) & 1));
                if (last) begin
                    checkOutput({tag, ".doneEarly"}, int'(bus3.frame_done), 0);
                    break;
                end
            end
        end
        @(negedge clk);
        driveBeat(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, ".done1"}, int'(bus1.frame_done), int'(expectDone));
        checkOutput({tag, ".done3"}, int'(bus3.frame_done), int'(expectDone));
        @(negedge clk);
        checkOutput({tag, ".doneDrop"}, int'(bus3.frame_done), 0);
    endtask

    task automatic setPattern(input int kind);
        pat = '0;
        for (int x = 0; x < 640; x++) begin
            if (kind == 1 && x >= 260 && x <= 299) pat[x] = 1'b1;
            if (kind == 2 && (x == 250 || x == 251 || (x >= 270 && x <= 339))) pat[x] = 1'b1;
            if (kind == 3 && x >= 240 && x <= 399 && (((x - 240) / 20) % 2 == 0)) pat[x] = 1'b1;
        end
    endtask

    initial begin
        driveBeat(1'b0, 1'b0, 1'b0, 1'b0);
        pat = '0;
        repeat (3) @(negedge clk);
        checkSet("reset", 1, expZero);
        checkSet("reset", 3, expZero);
        checkOutput("reset.done", int'(bus3.frame_done), 0);
        reset_n = 1'b1;

        setPattern(1);
        applyStimulus("t1", 3, 0, 1'b0, 1'b1);
        checkSet("t1", 1, expT1);
        checkSet("t1", 3, expT1);

        setPattern(2);
        applyStimulus("t2", 3, 0, 1'b0, 1'b1);
        checkSet("t2", 3, expT2r3);
        checkSet("t2", 1, expT2r1);

        setPattern(3);
        applyStimulus("t3", 3, 0, 1'b0, 1'b1);
        checkSet("t3", 1, expT3);
        checkSet("t3", 3, expT3);

        applyStimulus("t5", 1, 5, 1'b0, 1'b1);
        checkSet("t5", 3, expZero);

        setPattern(1);
        applyStimulus("t6pre", 3, 0, 1'b0, 1'b1);
        checkSet("t6pre", 3, expT1);
        applyStimulus("t6", 0, 0, 1'b0, 1'b1);
        checkSet("t6", 1, expZero);
        checkSet("t6", 3, expZero);

        applyStimulus("t4pre", 3, 0, 1'b0, 1'b1);
        checkSet("t4pre", 1, expT1);
        applyStimulus("t4rst", 3, 0, 1'b1, 1'b0);
        checkSet("t4after", 1, expZero);
        checkSet("t4after", 3, expZero);
        applyStimulus("t4clean", 3, 0, 1'b0, 1'b1);
        checkSet("t4clean", 1, expT1);
        checkSet("t4clean", 3, expT1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
